// File: rtl/sdram_dq_io.sv
// sdram_dq_io: registered bidirectional SDRAM DQ port.
// Write words leave from an output register that drives the pins one cycle after
// acceptance. Read words are captured CAS_LATENCY cycles after each READ
// command. After the last read returns, TURNAROUND idle cycles pass before
// the controller may drive the bus again, so controller and SDRAM never fight
// over DQ.
module sdram_dq_io #(
    parameter int WIDTH       = 16,
    parameter int CAS_LATENCY = 2,
    parameter int TURNAROUND  = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr_valid,
    input  logic [WIDTH-1:0] wr_data,
    output logic             wr_ready,
    input  logic             rd_req,
    output logic             rd_valid,
    output logic [WIDTH-1:0] rd_data,
    output logic             collision,
    output logic             dq_oe,
    inout  wire  [WIDTH-1:0] dq
);

    // Reject configurations the pipe and guard counter are not sized for.
    generate
        if (WIDTH < 1) begin : g_bad_width
            $error("sdram_dq_io: WIDTH must be at least 1");
        end
        if (CAS_LATENCY < 1 || CAS_LATENCY > 3) begin : g_bad_cl
            $error("sdram_dq_io: CAS_LATENCY must be in 1..3");
        end
        if (TURNAROUND < 0 || TURNAROUND > 3) begin : g_bad_ta
            $error("sdram_dq_io: TURNAROUND must be in 0..3");
        end
    endgenerate

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,  // bus released, writes allowed
        ST_WRITE = 2'd1,  // output register driving DQ
        ST_READ  = 2'd2,  // at least one read in flight
        ST_TURN  = 2'd3   // guard cycles after the last read word
    } state_t;

    localparam logic [1:0] TURN_LOAD = 2'(TURNAROUND);

    state_t                 state_q, state_d;
    logic                   oe_q, oe_d;
    logic [WIDTH-1:0]       out_q, out_d;
    logic [CAS_LATENCY:1]   pipe_q, pipe_d;
    logic [1:0]             cnt_q, cnt_d;
    logic                   wr_ready_q, wr_ready_d;
    logic                   rd_valid_q, rd_valid_d;
    logic [WIDTH-1:0]       rd_data_q, rd_data_d;
    logic                   collision_q, collision_d;

    logic                   wr_accept;
    logic                   capture;

    // A READ command always wins over a write offered in the same cycle.
    assign wr_accept = wr_valid & wr_ready_q & ~rd_req;

    // Stage CAS_LATENCY of the pipe marks the cycle the SDRAM is driving DQ.
    assign capture = pipe_q[CAS_LATENCY];

    // Read pipe: bit k set means a READ was issued k cycles ago.
    always_comb begin
        pipe_d    = '0;
        pipe_d[1] = rd_req;
        for (int i = 2; i <= CAS_LATENCY; i++) begin
            pipe_d[i] = pipe_q[i-1];
        end
    end

    // Bus-ownership FSM: next state, output enable, output register, guard counter.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        oe_d    = 1'b0;
        out_d   = out_q;

        case (state_q)
            ST_IDLE, ST_WRITE: begin
                if (wr_accept) begin
                    state_d = ST_WRITE;
                    oe_d    = 1'b1;
                    out_d   = wr_data;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_READ: begin
                // Leave READ on the edge that retires the last in-flight word.
                if (pipe_d == '0) begin
                    if (TURNAROUND > 0) begin
                        state_d = ST_TURN;
                        cnt_d   = TURN_LOAD;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            ST_TURN: begin
                // The final guard cycle hands the bus back on the next edge.
                if (cnt_q <= 2'd1) begin
                    state_d = ST_IDLE;
                    cnt_d   = 2'd0;
                end else begin
                    cnt_d = cnt_q - 2'd1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = 2'd0;
            end
        endcase

        // A new READ preempts everything, including a pending guard countdown.
        if (rd_req) begin
            state_d = ST_READ;
            oe_d    = 1'b0;
            cnt_d   = 2'd0;
        end
    end

    // Status and capture path computed alongside the FSM.
    always_comb begin
        wr_ready_d  = (state_d == ST_IDLE) || (state_d == ST_WRITE);
        collision_d = rd_req & wr_valid & wr_ready_q;
        rd_valid_d  = capture;
        rd_data_d   = capture ? dq : rd_data_q;
    end

    // Control registers: state, enable, pipe, counter and status pulses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            oe_q        <= 1'b0;
            pipe_q      <= '0;
            cnt_q       <= 2'd0;
            wr_ready_q  <= 1'b1;
            rd_valid_q  <= 1'b0;
            collision_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            oe_q        <= oe_d;
            pipe_q      <= pipe_d;
            cnt_q       <= cnt_d;
            wr_ready_q  <= wr_ready_d;
            rd_valid_q  <= rd_valid_d;
            collision_q <= collision_d;
        end
    end

    // Data registers: outgoing write word and last captured read word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_q     <= '0;
            rd_data_q <= '0;
        end else begin
            out_q     <= out_d;
            rd_data_q <= rd_data_d;
        end
    end

    assign dq        = oe_q ? out_q : {WIDTH{1'bz}};
    assign dq_oe     = oe_q;
    assign wr_ready  = wr_ready_q;
    assign rd_valid  = rd_valid_q;
    assign rd_data   = rd_data_q;
    assign collision = collision_q;

endmodule
